// File: rtl/barrel_rotl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrel_rotl_pipe
// Purpose  : Five-stage pipelined rotate-left barrel shifter, valid/ready on
//            both sides. Optional macro BARREL_ROTL_DIR_SEL_EN adds a per-beat
//            direction input (dir = 1 rotates right).
// Revision : 1.0 - initial release
// ============================================================================
module barrel_rotl_pipe #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] In,
  input  logic [4:0]   s,
`ifdef BARREL_ROTL_DIR_SEL_EN
  input  logic         dir,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
);

  localparam int unsigned c_amt0 = 1  % N;
  localparam int unsigned c_amt1 = 2  % N;
  localparam int unsigned c_amt2 = 4  % N;
  localparam int unsigned c_amt3 = 8  % N;
  localparam int unsigned c_amt4 = 16 % N;

  logic [4:0]   r_valid;
  logic [N-1:0] r_data [5];
  logic [3:0]   r_sh0;
  logic [2:0]   r_sh1;
  logic [1:0]   r_sh2;
  logic         r_sh3;
  logic [4:0]   w_ready;
  logic [4:0]   w_d;

  // amt is always below N, so the complementary shift never wraps past zero
  function automatic logic [N-1:0] f_step(input logic [N-1:0] x, input logic en,
                                          input int unsigned amt, input logic d);
    if (!en)
      return x;
    else if (d)
      return (x >> amt) | (x << (N - amt));
    else
      return (x << amt) | (x >> (N - amt));
  endfunction

  assign w_ready[4] = !r_valid[4] || out_ready;
  assign w_ready[3] = !r_valid[3] || w_ready[4];
  assign w_ready[2] = !r_valid[2] || w_ready[3];
  assign w_ready[1] = !r_valid[1] || w_ready[2];
  assign w_ready[0] = !r_valid[0] || w_ready[1];

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[4];
  assign out       = r_data[4];

`ifdef BARREL_ROTL_DIR_SEL_EN
  logic [3:0] r_dir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir <= '0;
    end else begin
      if (w_ready[0] && in_valid)   r_dir[0] <= dir;
      if (w_ready[1] && r_valid[0]) r_dir[1] <= r_dir[0];
      if (w_ready[2] && r_valid[1]) r_dir[2] <= r_dir[1];
      if (w_ready[3] && r_valid[2]) r_dir[3] <= r_dir[2];
    end
  end

  assign w_d = {r_dir, dir};
`else
  assign w_d = '0;
`endif

  // A stage with ready high takes the upstream valid, collapsing bubbles;
  // data only moves with a real beat so a held result never changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < 5; k++) r_data[k] <= '0;
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
      r_sh3 <= 1'b0;
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= f_step(In, s[0], c_amt0, w_d[0]);
          r_sh0     <= s[4:1];
        end
      end
      if (w_ready[1]) begin
        r_valid[1] <= r_valid[0];
        if (r_valid[0]) begin
          r_data[1] <= f_step(r_data[0], r_sh0[0], c_amt1, w_d[1]);
          r_sh1     <= r_sh0[3:1];
        end
      end
      if (w_ready[2]) begin
        r_valid[2] <= r_valid[1];
        if (r_valid[1]) begin
          r_data[2] <= f_step(r_data[1], r_sh1[0], c_amt2, w_d[2]);
          r_sh2     <= r_sh1[2:1];
        end
      end
      if (w_ready[3]) begin
        r_valid[3] <= r_valid[2];
        if (r_valid[2]) begin
          r_data[3] <= f_step(r_data[2], r_sh2[0], c_amt3, w_d[3]);
          r_sh3     <= r_sh2[1];
        end
      end
      if (w_ready[4]) begin
        r_valid[4] <= r_valid[3];
        if (r_valid[3])
          r_data[4] <= f_step(r_data[3], r_sh3, c_amt4, w_d[4]);
      end
    end
  end

endmodule
`default_nettype wire
